// File: rtl/ld_cell_sampler.sv
// ld_cell_sampler: periodically reads the left/right load cells through the SPI master and IIR-filters each result.
// Latency: first wrt the clk after a trig seen in IDLE; ld_vld the clk after the final read's done.
// Backpressure: waits on done indefinitely; one trig is queued while busy, further trigs are dropped.
// Optional macro BATT_SAMPLE_EN: appends a raw (unfiltered) battery conversion and adds the batt output.
module ld_cell_sampler #(
  parameter bit         fast_sim   = 1'b1,
  parameter int         SMPL_PER   = 1_048_576,
  parameter int         FILT_SHIFT = 2,
  parameter logic [2:0] LFT_CH     = 3'd0,
  parameter logic [2:0] RGHT_CH    = 3'd4
`ifdef BATT_SAMPLE_EN
  ,
  parameter logic [2:0] BATT_CH    = 3'd5
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic        ld_vld
`ifdef BATT_SAMPLE_EN
  ,
  output logic [11:0] batt
`endif
);

  localparam int PER = fast_sim ? 64 : SMPL_PER;
  localparam int TW  = (PER > 1) ? $clog2(PER) : 1;
  localparam logic [TW-1:0] PER_M1 = TW'(PER - 1);

  // Channel index inside one sequence; order is always left, right (, battery).
  localparam logic [1:0] CH_L = 2'd0;
  localparam logic [1:0] CH_R = 2'd1;
`ifdef BATT_SAMPLE_EN
  localparam logic [1:0] CH_B = 2'd2;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WAIT_CMD = 3'd2,
    RD       = 3'd3,
    WAIT_RD  = 3'd4,
    UPD      = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic          trig;
  logic          pend;
  logic          init;
  logic [1:0]    chi;
  logic [11:0]   smp;
  logic          unused_rd_hi;

  assign trig         = (tmr == PER_M1);
  assign smp          = rd_data[11:0];
  // Upper rd_data bits carry no conversion data.
  assign unused_rd_hi = ^rd_data[15:12];

  // One IIR step: y + ((s - y) >>> FILT_SHIFT). The 13-bit signed difference
  // keeps the sign, and the true result always lies between y and s, so
  // truncating back to 12 bits can never wrap.
  function automatic logic [11:0] filt(input logic [11:0] y, input logic [11:0] s);
    logic signed [12:0] d;
    logic signed [12:0] q;
    d = $signed({1'b0, s}) - $signed({1'b0, y});
    q = d >>> FILT_SHIFT;
    return y + q[11:0];
  endfunction

  // Free-running sample period timer; the wrap cycle is the trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (trig) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TW'(1);
    end
  end

  // Sequencer FSM with registered wrt/cmd/ld_vld and load capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wrt     <= 1'b0;
      cmd     <= '0;
      ld_vld  <= 1'b0;
      pend    <= 1'b0;
      init    <= 1'b1;
      chi     <= CH_L;
      lft_ld  <= '0;
      rght_ld <= '0;
`ifdef BATT_SAMPLE_EN
      batt    <= '0;
`endif
    end else begin
      wrt    <= 1'b0;
      cmd    <= '0;
      ld_vld <= 1'b0;
      // A trig that lands while a sequence is running is remembered once.
      if (trig && (state != IDLE)) begin
        pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trig || pend) begin
            state <= CMD;
            wrt   <= 1'b1;
            cmd   <= {2'b00, LFT_CH, 11'h000};
            chi   <= CH_L;
            pend  <= 1'b0;
          end
        end
        CMD: begin
          state <= WAIT_CMD;
        end
        WAIT_CMD: begin
          if (done) begin
            state <= RD;
            wrt   <= 1'b1;
          end
        end
        RD: begin
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (done) begin
            if (chi == CH_L) begin
              lft_ld <= init ? smp : filt(lft_ld, smp);
              chi    <= CH_R;
              state  <= CMD;
              wrt    <= 1'b1;
              cmd    <= {2'b00, RGHT_CH, 11'h000};
            end else if (chi == CH_R) begin
              rght_ld <= init ? smp : filt(rght_ld, smp);
`ifdef BATT_SAMPLE_EN
              chi     <= CH_B;
              state   <= CMD;
              wrt     <= 1'b1;
              cmd     <= {2'b00, BATT_CH, 11'h000};
`else
              state   <= UPD;
              ld_vld  <= 1'b1;
`endif
            end else begin
`ifdef BATT_SAMPLE_EN
              batt   <= smp;
`endif
              state  <= UPD;
              ld_vld <= 1'b1;
            end
          end
        end
        UPD: begin
          // First completed sequence after reset ends the raw-load phase.
          init  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld_cell_sampler.sv
// tb_ld_cell_sampler: randomized SPI responder plus transaction-level reference model for ld_cell_sampler.
// Latency: compares every cycle at the falling edge against expectations derived one cycle earlier.
// Backpressure: the SPI responder chooses the wrt-to-done delay per transaction.
module tb_ld_cell_sampler;

  localparam int FS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
`ifdef BATT_SAMPLE_EN
  logic [11:0] batt;
`endif

  ld_cell_sampler #(
    .fast_sim  (1'b1),
    .SMPL_PER  (1_048_576),
    .FILT_SHIFT(FS),
    .LFT_CH    (3'd0),
    .RGHT_CH   (3'd4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (done),
    .rd_data(rd_data),
    .lft_ld (lft_ld),
    .rght_ld(rght_ld),
    .ld_vld (ld_vld)
`ifdef BATT_SAMPLE_EN
    ,
    .batt   (batt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;

  // SPI responder state
  bit          spi_busy;
  int          spi_done_at;
  int          spi_txn;
  int          spi_ch;
  int          dmin, dmax;
  bit          spur_en;
  bit          rand_smp;
  logic [11:0] smp_l, smp_r;

  // Reference model state
  bit          m_busy, m_pend, m_out, m_init;
  int          m_txn;
  bit          e_wrt, e_vld;
  logic [15:0] e_cmd;
  int          e_lft, e_rght;

  // Observations for literal pins
  int          first_wrt;
  int          vld_cnt, last_vld, pend_starts;
  logic [15:0] cmdq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // Filter step from the arithmetic definition: floor division of the difference.
  function automatic int filt_m(input int y, input int s, input bit ini);
    int d, q, inc;
    if (ini) return s;
    d = s - y;
    q = 1 << FS;
    if (d >= 0) inc = d / q;
    else        inc = -((-d + q - 1) / q);
    return y + inc;
  endfunction

  // Compare cycle n, drive SPI inputs for cycle n, advance the model to cycle n+1.
  task automatic cycle_body();
    bit trig, nx_wrt, nx_vld, line_idle;
    logic [15:0] nx_cmd;

    chk("wrt", int'(wrt), int'(e_wrt));
    if (e_wrt) chk("cmd", int'(cmd), int'(e_cmd));
    chk("ld_vld", int'(ld_vld), int'(e_vld));
    chk("lft_ld", int'(lft_ld), e_lft);
    chk("rght_ld", int'(rght_ld), e_rght);

    if (wrt && first_wrt < 0) first_wrt = n;
    if (wrt && cmdq.size() < 4) cmdq.push_back(cmd);
    if (wrt && last_vld >= 0 && n == last_vld + 2) pend_starts++;
    if (ld_vld) begin
      vld_cnt++;
      last_vld = n;
    end

    // SPI responder
    line_idle = !spi_busy;
    done      = 1'b0;
    rd_data   = 16'($urandom);
    if (wrt) begin
      spi_busy    = 1'b1;
      spi_done_at = n + int'($urandom_range(dmax, dmin));
      if (spi_txn % 2 == 0) spi_ch = int'(cmd[13:11]);
    end else if (spi_busy && n == spi_done_at) begin
      done     = 1'b1;
      spi_busy = 1'b0;
      if (spi_txn % 2 == 1) begin
        if (rand_smp)         rd_data[11:0] = 12'($urandom);
        else if (spi_ch == 0) rd_data[11:0] = smp_l;
        else                  rd_data[11:0] = smp_r;
      end
      spi_txn++;
    end
    if (line_idle && spur_en && !done && $urandom_range(3, 0) == 0) done = 1'b1;

    // Reference model
    trig   = (n % 64 == 63);
    nx_wrt = 1'b0;
    nx_vld = 1'b0;
    nx_cmd = 16'h0000;
    if (m_busy) begin
      if (trig) m_pend = 1'b1;
      if (e_wrt) begin
        m_out = 1'b1;
      end else if (m_out && done) begin
        m_out = 1'b0;
        if (m_txn == 1) e_lft  = filt_m(e_lft, int'(rd_data[11:0]), m_init);
        if (m_txn == 3) e_rght = filt_m(e_rght, int'(rd_data[11:0]), m_init);
        m_txn++;
        if (m_txn < 4) begin
          nx_wrt = 1'b1;
          nx_cmd = (m_txn == 2) ? 16'h2000 : 16'h0000;
        end else begin
          nx_vld = 1'b1;
        end
      end
      if (e_vld) begin
        m_busy = 1'b0;
        m_init = 1'b0;
      end
    end else if (trig || m_pend) begin
      m_busy = 1'b1;
      m_pend = 1'b0;
      m_txn  = 0;
      nx_wrt = 1'b1;
      nx_cmd = 16'h0000;
    end
    e_wrt = nx_wrt;
    e_vld = nx_vld;
    e_cmd = nx_cmd;
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    cycle_body();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    done    = 1'b0;
    rd_data = 16'h0000;
    #1;
    chk("rst_wrt", int'(wrt), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_lft", int'(lft_ld), 0);
    chk("rst_rght", int'(rght_ld), 0);
    chk("rst_vld", int'(ld_vld), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    spi_busy = 1'b0; spi_done_at = -1; spi_txn = 0; spi_ch = 0;
    m_busy = 1'b0; m_pend = 1'b0; m_out = 1'b0; m_init = 1'b1; m_txn = 0;
    e_wrt = 1'b0; e_vld = 1'b0; e_cmd = 16'h0000; e_lft = 0; e_rght = 0;
    first_wrt = -1; vld_cnt = 0; last_vld = -1; pend_starts = 0;
    cmdq.delete();
    n = 0;
    cycle_body();
  endtask

  task automatic run_until_vld(input int k, input int budget);
    int c;
    c = 0;
    while (vld_cnt < k && c < budget) begin
      step();
      c++;
    end
    if (vld_cnt < k) chk("vld_timeout", vld_cnt, k);
  endtask

  initial begin
    int c;
    rst = 1'b0; done = 1'b0; rd_data = 16'h0000;
    dmin = 3; dmax = 3; spur_en = 1'b0; rand_smp = 1'b0;
    smp_l = 12'h300; smp_r = 12'h180;
    #2;
    do_reset();

    // First sequence: fixed T, raw load because of init.
    run_until_vld(1, 300);
    chk("first_wrt_cycle", first_wrt, 64);
    chk("first_vld_cycle", last_vld, 64 + 4 * (3 + 1));
    chk("cmd0", (cmdq.size() > 0) ? int'(cmdq[0]) : -1, 16'h0000);
    chk("cmd1", (cmdq.size() > 1) ? int'(cmdq[1]) : -1, 16'h0000);
    chk("cmd2", (cmdq.size() > 2) ? int'(cmdq[2]) : -1, 16'h2000);
    chk("cmd3", (cmdq.size() > 3) ? int'(cmdq[3]) : -1, 16'h0000);
    step();
    chk("lft_init", int'(lft_ld), 12'h300);
    chk("rght_init", int'(rght_ld), 12'h180);
    chk("vld_single", int'(ld_vld), 0);

    // Second sequence: filtered step down.
    smp_l = 12'h100;
    run_until_vld(2, 300);
    step();
    chk("lft_filt_down", int'(lft_ld), 12'h280);

    // Random samples, random T, spurious done pulses outside the wait states.
    rand_smp = 1'b1; dmin = 1; dmax = 8; spur_en = 1'b1;
    for (int i = 0; i < 2000; i++) step();

    // Stretched transactions: trigs arrive mid-sequence and are queued once.
    spur_en = 1'b0; dmin = 100; dmax = 100;
    for (int i = 0; i < 1500; i++) step();
    chk("pend_restart", int'(pend_starts >= 2), 1);

    // Reset while the right-channel read is outstanding.
    dmin = 5; dmax = 5;
    c = 0;
    while (!(m_busy && m_txn == 3 && m_out) && c < 500) begin
      step();
      c++;
    end
    chk("reach_right_rd", int'(m_busy && m_txn == 3 && m_out), 1);
    #2;
    do_reset();

    // Post-reset sequence reloads raw values.
    rand_smp = 1'b0; smp_l = 12'h0AB; smp_r = 12'h000;
    run_until_vld(1, 300);
    chk("rst_first_wrt", first_wrt, 64);
    step();
    chk("lft_reinit", int'(lft_ld), 12'h0AB);
    chk("rght_reinit", int'(rght_ld), 12'h000);

    // Full-scale step up after init.
    smp_r = 12'hFFF;
    run_until_vld(2, 300);
    step();
    chk("rght_filt_up", int'(rght_ld), 12'h3FF);
    for (int i = 0; i < 100; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
